// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI sampler.
//   state_t      : controller state encoding
//   frame_cycles : clk cycles from chip-select assertion to the accumulate step
package adc_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      ACCUM,
      PUBLISH
   } state_t;

   // CS setup + FRAME_BITS full SCLK periods + CS hold, all in CLK_DIV units.
   function automatic int frame_cycles(input int clk_div, input int frame_bits);
      return clk_div * (2 * frame_bits + 2);
   endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SCLK generator and MSB-first shift register for one ADC conversion frame.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   start      : one-cycle pulse, begins the first SCLK low phase on this edge
//   miso       : synchronized ADC data
//   sclk       : SPI clock, idles high
//   done       : one-cycle pulse on the edge that ends the last high phase
//   frame      : captured bits, first bit received ends up in the MSB
module spi_frame_rx #(
   parameter int CLK_DIV    = 7,
   parameter int FRAME_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  miso,
   output logic                  sclk,
   output logic                  done,
   output logic [FRAME_BITS-1:0] frame
);

   localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;
   localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LOAD  = BW'(FRAME_BITS - 1);

   logic          active;
   logic [HW-1:0] half_cnt;
   logic [BW-1:0] bit_cnt;

   // Last high phase expiring: the controller raises chip select on this edge.
   assign done = active && sclk && (half_cnt == '0) && (bit_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active   <= 1'b0;
         sclk     <= 1'b1;
         half_cnt <= '0;
         bit_cnt  <= '0;
         frame    <= '0;
      end else if (start) begin
         active   <= 1'b1;
         sclk     <= 1'b0;
         half_cnt <= HALF_LOAD;
         bit_cnt  <= BIT_LOAD;
      end else if (active) begin
         if (half_cnt != '0) begin
            half_cnt <= half_cnt - HW'(1);
         end else if (!sclk) begin
            // The ADC changed data on the falling edge; take it as SCLK rises.
            sclk     <= 1'b1;
            half_cnt <= HALF_LOAD;
            frame    <= {frame[FRAME_BITS-2:0], miso};
         end else if (bit_cnt == '0) begin
            active <= 1'b0;
         end else begin
            sclk     <= 1'b0;
            half_cnt <= HALF_LOAD;
            bit_cnt  <= bit_cnt - BW'(1);
         end
      end
   end

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic serial-ADC reader with 2^AVG_LOG2 averaging for the buck-boost loop.
// Ports:
//   clk, rst_n     : system clock, synchronous active-low reset
//   enable         : conversions run while high
//   spi_miso       : ADC serial data (asynchronous, synchronized here)
//   spi_cs_n       : ADC chip select, active-low
//   spi_sclk       : ADC serial clock, idles high
//   voltage_actual : averaged ADC code
//   ready          : high READY_HOLD cycles, rising with each new voltage_actual
//   busy           : high while a frame is on the bus
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for a sample tick with enable high
// CS_SETUP | cs_n low, sclk high for CLK_DIV cycles
// SHIFT    | spi_frame_rx clocks FRAME_BITS bits in
// CS_HOLD  | cs_n high for CLK_DIV cycles before the data is used
// ACCUM    | add data to the running sum, or drop the sum if disabled
// PUBLISH  | present the average, clear the sum, start the ready pulse
module adc_spi_sampler
   import adc_spi_pkg::*;
#(
   parameter int CLK_DIV       = 7,
   parameter int SAMPLE_PERIOD = 2700,
   parameter int FRAME_BITS    = 16,
   parameter int DATA_LSB      = 4,
   parameter int AVG_LOG2      = 2,
   parameter int READY_HOLD    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       spi_miso,
   output logic       spi_cs_n,
   output logic       spi_sclk,
   output logic [7:0] voltage_actual,
   output logic       ready,
   output logic       busy
);

   localparam int TW = $clog2(SAMPLE_PERIOD);
   localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [HW-1:0] HALF_LOAD = HW'(CLK_DIV - 1);
   localparam int AW = 8 + AVG_LOG2;
   localparam int CW = AVG_LOG2 + 1;
   localparam logic [CW-1:0] AVG_COUNT = CW'(1 << AVG_LOG2);
   localparam int RW = $clog2(READY_HOLD + 1);
   localparam logic [RW-1:0] HOLD_LOAD = RW'(READY_HOLD - 1);

   state_t                state;
   logic                  miso_meta;
   logic                  miso_sync;
   logic [TW-1:0]         tick_cnt;
   logic                  tick;
   logic [HW-1:0]         phase_cnt;
   logic [AW-1:0]         acc;
   logic [AW-1:0]         acc_next;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_next;
   logic [RW-1:0]         hold_cnt;
   logic                  rx_start;
   logic                  rx_done;
   logic [FRAME_BITS-1:0] rx_frame;
   logic [7:0]            sample;
   logic                  frame_unused;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         miso_meta <= 1'b0;
         miso_sync <= 1'b0;
      end else begin
         miso_meta <= spi_miso;
         miso_sync <= miso_meta;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TW'(1);
   end

   assign rx_start = (state == CS_SETUP) && (phase_cnt == '0);

   spi_frame_rx #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .start (rx_start),
      .miso  (miso_sync),
      .sclk  (spi_sclk),
      .done  (rx_done),
      .frame (rx_frame)
   );

   assign sample       = rx_frame[DATA_LSB+7:DATA_LSB];
   // Leading/trailing frame bits carry no data.
   assign frame_unused = ^rx_frame;
   // Width AW holds 2^AVG_LOG2 full-scale codes, so the sum cannot wrap.
   assign acc_next     = acc + AW'(sample);
   assign count_next   = count + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         spi_cs_n       <= 1'b1;
         busy           <= 1'b0;
         phase_cnt      <= '0;
         acc            <= '0;
         count          <= '0;
         voltage_actual <= '0;
         ready          <= 1'b0;
         hold_cnt       <= '0;
      end else begin
         if (ready) begin
            if (hold_cnt == '0)
               ready <= 1'b0;
            else
               hold_cnt <= hold_cnt - RW'(1);
         end

         case (state)
            IDLE: begin
               if (!enable) begin
                  acc   <= '0;
                  count <= '0;
               end else if (tick) begin
                  state     <= CS_SETUP;
                  spi_cs_n  <= 1'b0;
                  busy      <= 1'b1;
                  phase_cnt <= HALF_LOAD;
               end
            end
            CS_SETUP: begin
               if (phase_cnt == '0)
                  state <= SHIFT;
               else
                  phase_cnt <= phase_cnt - HW'(1);
            end
            SHIFT: begin
               if (rx_done) begin
                  state     <= CS_HOLD;
                  spi_cs_n  <= 1'b1;
                  phase_cnt <= HALF_LOAD;
               end
            end
            CS_HOLD: begin
               if (phase_cnt == '0) begin
                  state <= ACCUM;
                  busy  <= 1'b0;
               end else begin
                  phase_cnt <= phase_cnt - HW'(1);
               end
            end
            ACCUM: begin
               // A frame finished after enable dropped: discard the partial average.
               if (!enable) begin
                  acc   <= '0;
                  count <= '0;
                  state <= IDLE;
               end else begin
                  acc   <= acc_next;
                  count <= count_next;
                  state <= (count_next == AVG_COUNT) ? PUBLISH : IDLE;
               end
            end
            PUBLISH: begin
               voltage_actual <= acc[AW-1:AVG_LOG2];
               acc            <= '0;
               count          <= '0;
               ready          <= 1'b1;
               hold_cnt       <= HOLD_LOAD;
               state          <= IDLE;
            end
            default: begin
               state    <= IDLE;
               spi_cs_n <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_sampler.sv
`timescale 1ns/1ps
module tb_adc_spi_sampler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       en0 = 1'b0;
   logic       en2 = 1'b0;
   logic       miso0 = 1'b0;
   logic       miso2 = 1'b0;
   logic       cs_n0, sclk0, ready0, busy0;
   logic       cs_n2, sclk2, ready2, busy2;
   logic [7:0] v0, v2;

   int compared = 0;
   int mismatched = 0;

   // dut0: no averaging, default sample period
   adc_spi_sampler #(.AVG_LOG2(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(en0), .spi_miso(miso0),
      .spi_cs_n(cs_n0), .spi_sclk(sclk0), .voltage_actual(v0),
      .ready(ready0), .busy(busy0)
   );

   // dut2: 4-sample average, shortened sample period to keep runs short
   adc_spi_sampler #(.SAMPLE_PERIOD(300), .AVG_LOG2(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .spi_miso(miso2),
      .spi_cs_n(cs_n2), .spi_sclk(sclk2), .voltage_actual(v2),
      .ready(ready2), .busy(busy2)
   );

   // ADC models: word loaded at CS fall, next bit driven on each SCLK fall.
   // Non-zero padding around the code exposes any misplaced data window.
   logic [15:0] w0 = '0;
   logic [15:0] w2 = '0;
   logic [7:0]  codes2[$];

   always @(negedge cs_n0) w0 = {4'b0001, 8'hA5, 4'b1000};
   always @(negedge sclk0) if (!cs_n0) begin miso0 = w0[15]; w0 = {w0[14:0], 1'b0}; end

   always @(negedge cs_n2) begin
      logic [7:0] c;
      c = 8'h00;
      if (codes2.size() > 0) c = codes2.pop_front();
      w2 = {4'b0001, c, 4'b1000};
   end
   always @(negedge sclk2) if (!cs_n2) begin miso2 = w2[15]; w2 = {w2[14:0], 1'b0}; end

   task automatic load4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
      codes2.push_back(a); codes2.push_back(b); codes2.push_back(c); codes2.push_back(d);
   endtask

   // Ends on a falling edge with reset released; the next rising edge is cycle 1.
   task automatic do_reset(input logic e0, input logic e2);
      @(negedge clk);
      rst_n = 1'b0; en0 = 1'b0; en2 = 1'b0;
      repeat (3) @(negedge clk);
      en0 = e0; en2 = e2; rst_n = 1'b1;
   endtask

   // Observes dut2 for ncyc cycles, cycle numbers counted from the call.
   task automatic run2(input int ncyc, output int rises, output int first_rise, output logic [7:0] v_first,
                       output int highs, output int cs_falls, output int first_cs_rise);
      logic prev_rdy, prev_cs;
      rises = 0; first_rise = -1; v_first = '0; highs = 0; cs_falls = 0; first_cs_rise = -1;
      prev_rdy = ready2; prev_cs = cs_n2;
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk); @(negedge clk);
         if (ready2) highs++;
         if (ready2 && !prev_rdy) begin
            rises++;
            if (first_rise < 0) begin first_rise = i; v_first = v2; end
         end
         if (!cs_n2 && prev_cs) cs_falls++;
         if (cs_n2 && !prev_cs && first_cs_rise < 0) first_cs_rise = i;
         prev_rdy = ready2; prev_cs = cs_n2;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; en0 = 1'b1; en2 = 1'b1;
      repeat (2) @(negedge clk);
      compared++; if ({cs_n0, sclk0, ready0, busy0} !== 4'b1100) begin mismatched++; $display("FAIL reset_ctl0: got %b expected 1100", {cs_n0, sclk0, ready0, busy0}); end
      compared++; if (v0 !== 8'h00) begin mismatched++; $display("FAIL reset_v0: got %h expected 00", v0); end
      compared++; if ({cs_n2, sclk2, ready2, busy2} !== 4'b1100) begin mismatched++; $display("FAIL reset_ctl2: got %b expected 1100", {cs_n2, sclk2, ready2, busy2}); end
      compared++; if (v2 !== 8'h00) begin mismatched++; $display("FAIL reset_v2: got %h expected 00", v2); end
   endtask

   task automatic test_single_frame();
      logic prev_cs, prev_sclk, prev_rdy;
      int cs_fall, cs_low, busy_hi, pulses, w, wmin, wmax, rdy_rise, rdy_hi;
      logic [7:0] v_at;
      cs_fall = -1; cs_low = 0; busy_hi = 0; pulses = 0; w = 0; wmin = 1000; wmax = 0;
      rdy_rise = -1; rdy_hi = 0; v_at = '0;
      do_reset(1'b1, 1'b0);
      prev_cs = cs_n0; prev_sclk = sclk0; prev_rdy = ready0;
      for (int i = 1; i <= 2960; i++) begin
         @(posedge clk); @(negedge clk);
         if (!cs_n0 && prev_cs && cs_fall < 0) cs_fall = i;
         if (!cs_n0) cs_low++;
         if (busy0) busy_hi++;
         if (!sclk0) w++;
         if (sclk0 && !prev_sclk) begin
            pulses++;
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
            w = 0;
         end
         if (ready0) rdy_hi++;
         if (ready0 && !prev_rdy && rdy_rise < 0) begin rdy_rise = i; v_at = v0; end
         prev_cs = cs_n0; prev_sclk = sclk0; prev_rdy = ready0;
      end
      compared++; if (cs_fall !== 2700) begin mismatched++; $display("FAIL single_cs_start: got %0d expected 2700", cs_fall); end
      compared++; if (cs_low !== 231) begin mismatched++; $display("FAIL single_cs_low: got %0d expected 231", cs_low); end
      compared++; if (busy_hi !== 238) begin mismatched++; $display("FAIL single_busy: got %0d expected 238", busy_hi); end
      compared++; if (pulses !== 16) begin mismatched++; $display("FAIL single_sclk_pulses: got %0d expected 16", pulses); end
      compared++; if (wmin !== 7 || wmax !== 7) begin mismatched++; $display("FAIL single_sclk_low_width: got %0d..%0d expected 7..7", wmin, wmax); end
      compared++; if (rdy_rise !== 2940) begin mismatched++; $display("FAIL single_ready_time: got %0d expected 2940", rdy_rise); end
      compared++; if (v_at !== 8'hA5) begin mismatched++; $display("FAIL single_value: got %h expected a5", v_at); end
      compared++; if (rdy_hi !== 8) begin mismatched++; $display("FAIL single_ready_width: got %0d expected 8", rdy_hi); end
      compared++; if (v0 !== 8'hA5) begin mismatched++; $display("FAIL single_value_hold: got %h expected a5", v0); end
      en0 = 1'b0;
   endtask

   task automatic test_average();
      int r, fr, h, cf, cr;
      logic [7:0] vf;
      codes2.delete();
      load4(8'd10, 8'd20, 8'd30, 8'd41);
      do_reset(1'b0, 1'b1);
      run2(1500, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1) begin mismatched++; $display("FAIL avg_ready_count: got %0d expected 1", r); end
      compared++; if (fr !== 1440) begin mismatched++; $display("FAIL avg_ready_time: got %0d expected 1440", fr); end
      compared++; if (vf !== 8'd25) begin mismatched++; $display("FAIL avg_value: got %0d expected 25", vf); end
      compared++; if (h !== 8) begin mismatched++; $display("FAIL avg_ready_width: got %0d expected 8", h); end
      compared++; if (cf !== 5) begin mismatched++; $display("FAIL avg_frames: got %0d expected 5", cf); end
   endtask

   task automatic test_max_code();
      int r, fr, h, cf, cr;
      logic [7:0] vf;
      codes2.delete();
      load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      do_reset(1'b0, 1'b1);
      run2(1450, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || fr !== 1440) begin mismatched++; $display("FAIL max_ready: got %0d rises at %0d expected 1 at 1440", r, fr); end
      compared++; if (vf !== 8'hFF) begin mismatched++; $display("FAIL max_value: got %h expected ff", vf); end
   endtask

   task automatic test_reset_mid_frame();
      int r, fr, h, cf, cr;
      logic [7:0] vf;
      codes2.delete();
      load4(8'hF0, 8'hF0, 8'hF0, 8'h11);
      codes2.push_back(8'h22); codes2.push_back(8'h33); codes2.push_back(8'h44);
      do_reset(1'b0, 1'b1);
      // third frame: CS_SETUP at 900, SHIFT from 907, cycle 1007 is 100 cycles into SHIFT
      run2(1007, r, fr, vf, h, cf, cr);
      compared++; if (r !== 0) begin mismatched++; $display("FAIL rst_pre_ready: got %0d expected 0", r); end
      compared++; if ({cs_n2, sclk2, busy2} !== 3'b001) begin mismatched++; $display("FAIL rst_pre_bus: got %b expected 001", {cs_n2, sclk2, busy2}); end
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      compared++; if ({cs_n2, sclk2, busy2} !== 3'b110) begin mismatched++; $display("FAIL rst_mid_bus: got %b expected 110", {cs_n2, sclk2, busy2}); end
      rst_n = 1'b1;
      run2(1450, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || fr !== 1440) begin mismatched++; $display("FAIL rst_post_ready: got %0d rises at %0d expected 1 at 1440", r, fr); end
      // (0x11+0x22+0x33+0x44)>>2 = 170>>2 = 42
      compared++; if (vf !== 8'h2A) begin mismatched++; $display("FAIL rst_post_value: got %h expected 2a", vf); end
   endtask

   task automatic test_enable_drop();
      int r, fr, h, cf, cr;
      logic [7:0] vf;
      codes2.delete();
      load4(8'h40, 8'h40, 8'h40, 8'h40);
      codes2.push_back(8'h80); codes2.push_back(8'h80);
      load4(8'h20, 8'h20, 8'h20, 8'h20);
      do_reset(1'b0, 1'b1);
      run2(1900, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || vf !== 8'h40) begin mismatched++; $display("FAIL en_first_publish: got %0d rises value %h expected 1 value 40", r, vf); end
      compared++; if (cf !== 6) begin mismatched++; $display("FAIL en_frames_before: got %0d expected 6", cf); end
      // drop enable 100 cycles into the sixth frame (started at 1800)
      en2 = 1'b0;
      run2(600, r, fr, vf, h, cf, cr);
      compared++; if (cr !== 131) begin mismatched++; $display("FAIL en_frame_completes: got cs rise at %0d expected 131", cr); end
      compared++; if (r !== 0) begin mismatched++; $display("FAIL en_no_ready: got %0d expected 0", r); end
      compared++; if (cf !== 0) begin mismatched++; $display("FAIL en_no_new_frames: got %0d expected 0", cf); end
      compared++; if (v2 !== 8'h40) begin mismatched++; $display("FAIL en_value_kept: got %h expected 40", v2); end
      en2 = 1'b1;
      // ticks at 2700..3600 since reset, i.e. 200..1100 from here; publish at 1340
      run2(1400, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || fr !== 1340) begin mismatched++; $display("FAIL en_resume_ready: got %0d rises at %0d expected 1 at 1340", r, fr); end
      compared++; if (vf !== 8'h20) begin mismatched++; $display("FAIL en_resume_value: got %h expected 20", vf); end
   endtask

   task automatic test_back_to_back();
      int r, fr, h, cf, cr;
      logic [7:0] vf;
      codes2.delete();
      load4(8'd8, 8'd8, 8'd8, 8'd8);
      load4(8'd100, 8'd101, 8'd102, 8'd103);
      do_reset(1'b0, 1'b1);
      run2(1450, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || vf !== 8'd8) begin mismatched++; $display("FAIL b2b_first: got %0d rises value %0d expected 1 value 8", r, vf); end
      run2(1200, r, fr, vf, h, cf, cr);
      compared++; if (r !== 1 || fr !== 1190) begin mismatched++; $display("FAIL b2b_second_ready: got %0d rises at %0d expected 1 at 1190", r, fr); end
      // 406>>2 = 101 (fraction truncated)
      compared++; if (vf !== 8'd101) begin mismatched++; $display("FAIL b2b_second_value: got %0d expected 101", vf); end
      compared++; if (h !== 8) begin mismatched++; $display("FAIL b2b_ready_width: got %0d expected 8", h); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_average();
      test_max_code();
      test_reset_mid_frame();
      test_enable_drop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
